// File: rtl/input_debouncer_if.sv
// Signal bundle for the multi-channel debouncer: raw inputs in, clean levels
// and per-channel busy flags out.
interface input_debouncer_if #(
    parameter int N = 4
);
    logic [N-1:0] in;
    logic [N-1:0] out;
    logic [N-1:0] busy;

    // master drives the raw inputs and observes the results; slave is the debouncer
    modport master (output in, input out, input busy);
    modport slave  (input in, output out, output busy);
endinterface

// File: rtl/input_debouncer.sv
// Per-channel synchroniser plus STABLE/PENDING debounce FSM: a level change on
// a channel is accepted only after DEBOUNCE_CYCLES consecutive stable clocks.
module input_debouncer #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit INIT_LEVEL      = 1'b0
) (
    input logic            clk,
    input logic            rst,
    input_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [N-1:0] lvl_vec;
    logic [N-1:0] busy_vec;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] chain;
        logic                   s;
        state_t                 state, state_nxt;
        logic [CNT_W-1:0]       cnt, cnt_nxt;
        logic                   lvl, lvl_nxt;

        // Pure shift chain: nothing between stages so each flop can resolve metastability.
        assign s = chain[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= {SYNC_STAGES{INIT_LEVEL}};
                state <= STABLE;
                cnt   <= '0;
                lvl   <= INIT_LEVEL;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], bus.in[i]};
                state <= state_nxt;
                cnt   <= cnt_nxt;
                lvl   <= lvl_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            lvl_nxt   = lvl;
            case (state)
                STABLE: begin
                    if (s != lvl) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            lvl_nxt = s;
                        end else begin
                            state_nxt = PENDING;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PENDING: begin
                    // A bounce back to the current level discards all accumulated time.
                    if (s == lvl) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                        lvl_nxt   = s;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign lvl_vec[i]  = lvl;
        assign busy_vec[i] = (state == PENDING);
    end

    assign bus.out  = lvl_vec;
    assign bus.busy = busy_vec;
endmodule
